mdu_seq_ctrl: RTL and testbench

// Sequencer for the multi-cycle multiply/divide unit (MDU) in the EX stage.
// - On an M-extension op in EX: starts the MDU, holds the pipeline while it works,

---
 rtl/mdu_seq_ctrl_pkg.sv | 30 +++
 rtl/mdu_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_mdu_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mdu_seq_ctrl_pkg
// Shared definitions for the EX-stage multiply/divide sequencer:
//   - mdu_state_e : sequencer FSM state encoding
//   - MDU_OP_*    : M-extension funct3 encodings
//   - mdu_is_div  : classifies an op as divide/remainder (funct3 bit 2)
// ---------------------------------------------------------------------------
package mdu_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    localparam logic [2:0] MDU_OP_MUL    = 3'b000;
    localparam logic [2:0] MDU_OP_MULH   = 3'b001;
    localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
    localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
    localparam logic [2:0] MDU_OP_DIV    = 3'b100;
    localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
    localparam logic [2:0] MDU_OP_REM    = 3'b110;
    localparam logic [2:0] MDU_OP_REMU   = 3'b111;

    // Divide and remainder ops all have funct3[2] set.
    function automatic logic mdu_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/mdu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_seq_ctrl
// Sequencer for the multi-cycle multiply/divide unit in the EX stage. Starts
// the unit on an M-extension op, stalls the front of the pipeline while the
// unit works, captures the result and presents it for one release cycle.
//
// Ports:
//   clk, rst_n     core clock, asynchronous active-low reset
//   mdu_en_EX      EX holds a valid M-extension op
//   mdu_op_EX[2:0] funct3 of the op (bit 2 = divide class)
//   div_zero_EX    divisor is zero (only meaningful for divide-class ops)
//   kill_EX        EX instruction squashed; abort any operation
//   unit_result_i  unit result, valid in the BUSY cycle where cnt == 0
//   unit_start_o   one-cycle start pulse to the unit
//   unit_op_o      op presented to the unit, stable from start through DONE
//   stall_mdu_o    hold PC, IF/ID and ID/EX; bubble into EX/MEM
//   done_o         result valid, EX instruction advances this cycle
//   result_o       captured result (zero outside DONE)
// ---------------------------------------------------------------------------
module mdu_seq_ctrl
    import mdu_seq_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdu_en_EX,
    input  logic [2:0]  mdu_op_EX,
    input  logic        div_zero_EX,
    input  logic        kill_EX,
    input  logic [31:0] unit_result_i,
    output logic        unit_start_o,
    output logic [2:0]  unit_op_o,
    output logic        stall_mdu_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    // Counter preload: the start cycle plus (LAT-1)+1 BUSY cycles gives LAT+1
    // stall cycles before DONE.
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       result_q, result_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree leaves one unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        result_d     = result_q;
        unit_start_o = 1'b0;
        unit_op_o    = op_q;
        stall_mdu_o  = 1'b0;
        done_o       = 1'b0;
        result_o     = '0;

        if (kill_EX) begin
            // Abort wins in every state; result_q keeps its old value and no
            // late unit result is captured.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mdu_en_EX) begin
                        unit_start_o = 1'b1;
                        stall_mdu_o  = 1'b1;
                        // The latch happens at the edge; show the live op in
                        // the start cycle so the unit sees it immediately.
                        unit_op_o    = mdu_op_EX;
                        op_d         = mdu_op_EX;
                        state_d      = BUSY;
                        if (mdu_is_div(mdu_op_EX)) begin
                            // Divide by zero has a fixed architectural result,
                            // so the unit answers in its first BUSY cycle.
                            cnt_d = div_zero_EX ? '0 : DIV_CNT_INIT;
                        end else begin
                            cnt_d = MUL_CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    stall_mdu_o = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        result_d = unit_result_i;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    // mdu_en_EX here belongs to the retiring instruction, so
                    // it must not restart the unit.
                    done_o   = 1'b1;
                    result_o = result_q;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // While reset is held the state is IDLE, but a live mdu_en_EX would
        // otherwise leak a start/stall; force the outputs quiet.
        if (!rst_n) begin
            unit_start_o = 1'b0;
            unit_op_o    = '0;
            stall_mdu_o  = 1'b0;
            done_o       = 1'b0;
            result_o     = '0;
        end
    end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_seq_ctrl
// Self-checking bench for mdu_seq_ctrl (MUL_LAT=2, DIV_LAT=32). Expected
// results are queued when an op is issued and compared when done_o rises.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_mdu_seq_ctrl;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULHU = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_REM   = 3'b110;

    localparam int MUL_STALL = MUL_LAT + 1;
    localparam int DIV_STALL = DIV_LAT + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mdu_en_EX;
    logic [2:0]  mdu_op_EX;
    logic        div_zero_EX;
    logic        kill_EX;
    logic [31:0] unit_result_i;
    logic        unit_start_o;
    logic [2:0]  unit_op_o;
    logic        stall_mdu_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mdu_seq_ctrl #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mdu_en_EX    (mdu_en_EX),
        .mdu_op_EX    (mdu_op_EX),
        .div_zero_EX  (div_zero_EX),
        .kill_EX      (kill_EX),
        .unit_result_i(unit_result_i),
        .unit_start_o (unit_start_o),
        .unit_op_o    (unit_op_o),
        .stall_mdu_o  (stall_mdu_o),
        .done_o       (done_o),
        .result_o     (result_o)
    );

    // Scoreboard: every done_o must retire the oldest queued result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: result_o=%h with no op pending", result_o);
            end else begin
                logic [31:0] exp;
                exp = exp_q.pop_front();
                if (result_o !== exp) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", result_o, exp);
                end
            end
        end
    end

    // Issues one op starting at the current drive point and runs it until
    // done_o (bounded). unit_result_i carries the real value only in the cycle
    // the sequencer should capture it (start cycle index stall_exp-1).
    // Leaves mdu_en_EX asserted; returns at the drive point after DONE.
    task automatic drive_op(input logic [2:0] op, input logic dz, input logic [31:0] res,
                            input int stall_exp, output int stall_cnt, output int start_cnt,
                            output int done_cyc, output bit op_ok, output bit zero_ok);
        stall_cnt = 0;
        start_cnt = 0;
        done_cyc  = -1;
        op_ok     = 1'b1;
        zero_ok   = 1'b1;
        mdu_en_EX   = 1'b1;
        mdu_op_EX   = op;
        div_zero_EX = dz;
        exp_q.push_back(res);
        for (int cyc = 0; cyc < stall_exp + 10 && done_cyc < 0; cyc++) begin
            unit_result_i = (cyc == stall_exp - 1) ? res : 32'hDEAD_BEEF;
            @(negedge clk);
            if (unit_start_o) start_cnt++;
            if (stall_mdu_o) stall_cnt++;
            if (unit_op_o !== op) op_ok = 1'b0;
            if (!done_o && result_o !== 32'h0) zero_ok = 1'b0;
            if (done_o) done_cyc = cyc;
            @(posedge clk); #1;
        end
        if (done_cyc < 0) exp_q.pop_back();
    endtask

    task automatic check_op(input string name, input int stall_cnt, input int start_cnt,
                            input int done_cyc, input bit op_ok, input bit zero_ok,
                            input int stall_exp);
        checks++;
        if (stall_cnt != stall_exp) begin
            errors++;
            $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stall_cnt, stall_exp);
        end
        checks++;
        if (done_cyc != stall_exp) begin
            errors++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_cyc, stall_exp);
        end
        checks++;
        if (start_cnt != 1) begin
            errors++;
            $display("FAIL %s_start_pulses: got %0d expected 1", name, start_cnt);
        end
        checks++;
        if (!op_ok) begin
            errors++;
            $display("FAIL %s_unit_op_stable: got unstable expected held", name);
        end
        checks++;
        if (!zero_ok) begin
            errors++;
            $display("FAIL %s_result_zero_outside_done: got nonzero expected 0", name);
        end
    endtask

    task automatic idle_cycle(input string name);
        mdu_en_EX   = 1'b0;
        div_zero_EX = 1'b0;
        @(negedge clk);
        checks++;
        if ({done_o, stall_mdu_o, unit_start_o} !== 3'b000) begin
            errors++;
            $display("FAIL %s_idle_after: got done/stall/start=%b expected 000", name,
                     {done_o, stall_mdu_o, unit_start_o});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mdu_en_EX = 1'b1;
        mdu_op_EX = OP_DIVU;
        div_zero_EX = 1'b0;
        kill_EX = 1'b0;
        unit_result_i = 32'h5555_AAAA;
        #3;
        checks++;
        if ({unit_start_o, stall_mdu_o, done_o} !== 3'b000 || unit_op_o !== 3'b000 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got start/stall/done=%b op=%b res=%h expected all 0",
                     {unit_start_o, stall_mdu_o, done_o}, unit_op_o, result_o);
        end
        mdu_en_EX = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle_cycle("reset");
    endtask

    task automatic test_mul();
        int s, st, d; bit ok, z;
        drive_op(OP_MUL, 1'b0, 32'h0000_0006, MUL_STALL, s, st, d, ok, z);
        check_op("mul", s, st, d, ok, z, MUL_STALL);
        idle_cycle("mul");
    endtask

    task automatic test_divu();
        int s, st, d; bit ok, z;
        drive_op(OP_DIVU, 1'b0, 32'h1234_5678, DIV_STALL, s, st, d, ok, z);
        check_op("divu", s, st, d, ok, z, DIV_STALL);
        idle_cycle("divu");
    endtask

    task automatic test_div_zero();
        int s, st, d; bit ok, z;
        drive_op(OP_DIV, 1'b1, 32'hFFFF_FFFF, 2, s, st, d, ok, z);
        check_op("div_zero", s, st, d, ok, z, 2);
        idle_cycle("div_zero");
        // div_zero_EX only shortens divide-class ops.
        drive_op(OP_MULHU, 1'b1, 32'h0000_CAFE, MUL_STALL, s, st, d, ok, z);
        check_op("mul_dz_ignored", s, st, d, ok, z, MUL_STALL);
        idle_cycle("mul_dz_ignored");
    endtask

    task automatic test_kill();
        int s, st, d; bit ok, z;
        bit stall_ok = 1'b1;
        mdu_en_EX   = 1'b1;
        mdu_op_EX   = OP_DIV;
        div_zero_EX = 1'b0;
        unit_result_i = 32'hBAD0_BAD0;
        // Start cycle loads DIV_LAT-1; BUSY cycle k has cnt = DIV_LAT-k.
        for (int cyc = 0; cyc < DIV_LAT - 10; cyc++) begin
            @(negedge clk);
            if (stall_mdu_o !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (!stall_ok) begin
            errors++;
            $display("FAIL kill_pre_stall: got gap expected continuous stall");
        end
        kill_EX = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall_mdu_o, done_o, unit_start_o} !== 3'b000) begin
            errors++;
            $display("FAIL kill_same_cycle: got stall/done/start=%b expected 000",
                     {stall_mdu_o, done_o, unit_start_o});
        end
        @(posedge clk); #1;
        kill_EX = 1'b0;
        mdu_en_EX = 1'b0;
        stall_ok = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (stall_mdu_o !== 1'b0 || done_o !== 1'b0) stall_ok = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (!stall_ok) begin
            errors++;
            $display("FAIL kill_idle_after: got stall or done expected quiet IDLE");
        end
        drive_op(OP_MUL, 1'b0, 32'h0000_0042, MUL_STALL, s, st, d, ok, z);
        check_op("mul_after_kill", s, st, d, ok, z, MUL_STALL);
        idle_cycle("mul_after_kill");
    endtask

    task automatic test_back_to_back();
        int s, st, d; bit ok, z;
        drive_op(OP_MUL, 1'b0, 32'h0000_0007, MUL_STALL, s, st, d, ok, z);
        check_op("b2b_mul", s, st, d, ok, z, MUL_STALL);
        // Next op issues in the cycle right after DONE.
        drive_op(OP_REM, 1'b0, 32'h0000_0009, DIV_STALL, s, st, d, ok, z);
        check_op("b2b_rem", s, st, d, ok, z, DIV_STALL);
        idle_cycle("b2b");
    endtask

    task automatic test_reset_mid_busy();
        bit quiet = 1'b1;
        mdu_en_EX   = 1'b1;
        mdu_op_EX   = OP_DIVU;
        div_zero_EX = 1'b0;
        unit_result_i = 32'h7777_7777;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({unit_start_o, stall_mdu_o, done_o} !== 3'b000 || unit_op_o !== 3'b000 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_busy: got start/stall/done=%b op=%b res=%h expected all 0",
                     {unit_start_o, stall_mdu_o, done_o}, unit_op_o, result_o);
        end
        mdu_en_EX = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < DIV_STALL + 5; cyc++) begin
            @(negedge clk);
            if (stall_mdu_o !== 1'b0 || done_o !== 1'b0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL reset_release_quiet: got stall or done expected none");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_divu();
        test_div_zero();
        test_kill();
        test_back_to_back();
        test_reset_mid_busy();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
